dma_protocol_monitor: RTL

- Synthesizable, parametrised monitor for the DMA controller's timing-and-control handshake. Successor to the simulation-only SVA checker, with N channels instead of a fixed 4.
- Samples the controller state vector and the bus/handshake pins. Flags eight protocol rules into sticky registers, a first-error capture and a saturating error counter.
- Optionally counts coverage events.
- Instantiated beside the DMA core, either in the bench or in silicon debug builds.

---
 rtl/dma_mon_pkg.sv | 41 ++++
 rtl/dma_protocol_monitor_if.sv | 13 +
 rtl/dma_mon_sat_cnt.sv | 15 +
 rtl/dma_protocol_monitor.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dma_mon_pkg.sv
// Shared definitions for the DMA protocol monitor: one-hot state codes,
// check identifiers and the legal state-transition table.
package dma_mon_pkg;

  localparam logic [5:0] ST_SI = 6'b000001;
  localparam logic [5:0] ST_SO = 6'b000010;
  localparam logic [5:0] ST_S1 = 6'b000100;
  localparam logic [5:0] ST_S2 = 6'b001000;
  localparam logic [5:0] ST_S3 = 6'b010000;
  localparam logic [5:0] ST_S4 = 6'b100000;

  localparam int NUM_CHECKS = 8;

  typedef enum logic [2:0] {
    CHK_ONEHOT        = 3'd0,
    CHK_ILLEGAL_TRANS = 3'd1,
    CHK_SO_EXIT       = 3'd2,
    CHK_DACK_MULTI    = 3'd3,
    CHK_DACK_NOREQ    = 3'd4,
    CHK_DACK_IDLE     = 3'd5,
    CHK_IORW_BOTH     = 3'd6,
    CHK_CS_ACTIVE     = 3'd7
  } chk_id_e;

  // Only meaningful when both codes are one-hot; callers gate on that.
  function automatic logic legal_trans(input logic [5:0] cur, input logic [5:0] nxt);
    logic ok;
    ok = 1'b0;
    case (cur)
      ST_SI:   ok = (nxt == ST_SI) || (nxt == ST_SO);
      ST_SO:   ok = (nxt == ST_SO) || (nxt == ST_S1) || (nxt == ST_SI);
      ST_S1:   ok = (nxt == ST_S2);
      ST_S2:   ok = (nxt == ST_S3);
      ST_S3:   ok = (nxt == ST_S3) || (nxt == ST_S4);
      ST_S4:   ok = (nxt == ST_S1) || (nxt == ST_S2) || (nxt == ST_SI);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dma_protocol_monitor_if.sv
// DMA controller handshake bundle as seen by the protocol monitor.
interface dma_protocol_monitor_if #(parameter int NUM_CH = 4);
  logic [5:0]        state;
  logic              CS_N;
  logic              HLDA;
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] DACK;
  logic              IOR_N;
  logic              IOW_N;

  modport master (output state, CS_N, HLDA, DREQ, DACK, IOR_N, IOW_N);
  modport slave  (input  state, CS_N, HLDA, DREQ, DACK, IOR_N, IOW_N);
endinterface

// File: rtl/dma_mon_sat_cnt.sv
// Saturating up-counter; clr wins over the old value but still counts the
// increment of the same cycle.
module dma_mon_sat_cnt #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)             q <= '0;
    else if (clr)           q <= CNT_W'(inc);
    else if (inc && ~&q)    q <= q + CNT_W'(1);
  end
endmodule

// File: rtl/dma_protocol_monitor.sv
// Synthesizable DMA handshake protocol monitor: eight sticky rule checks,
// first-error capture and error counter. DMA_MON_COVER_EN adds coverage counters.
module dma_protocol_monitor
  import dma_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    clr,
  dma_protocol_monitor_if.slave   bus,
  output logic [NUM_CHECKS-1:0]   err_sticky,
  output logic                    err_pulse,
  output logic                    first_err_valid,
  output logic [2:0]              first_err_id,
  output logic [CNT_W-1:0]        err_count,
  output logic [NUM_CH*CNT_W-1:0] dack_count,
  output logic [CNT_W-1:0]        so_visits
);

  logic [5:0]            prev_state;
  logic                  prev_valid;
  logic [NUM_CH-1:0]     prev_dreq;
  logic [NUM_CH-1:0]     prev_dack;
  logic                  prev_cs_n;
  logic                  prev_hlda;

  logic [NUM_CHECKS-1:0] chk;
  logic [2:0]            low_id;
  logic                  any_err;
  logic                  cur_oh, prev_oh;

  // Previous-sample registers run independently of clr.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      prev_state <= ST_SI;
      prev_valid <= 1'b0;
      prev_dreq  <= '0;
      prev_dack  <= '0;
      prev_cs_n  <= 1'b0;
      prev_hlda  <= 1'b0;
    end else begin
      prev_state <= bus.state;
      prev_valid <= 1'b1;
      prev_dreq  <= bus.DREQ;
      prev_dack  <= bus.DACK;
      prev_cs_n  <= bus.CS_N;
      prev_hlda  <= bus.HLDA;
    end
  end

  always_comb begin
    chk     = '0;
    cur_oh  = $onehot(bus.state);
    prev_oh = $onehot(prev_state);
    chk[CHK_ONEHOT]        = !cur_oh;
    chk[CHK_ILLEGAL_TRANS] = prev_valid && cur_oh && prev_oh &&
                             !legal_trans(prev_state, bus.state);
    chk[CHK_SO_EXIT]       = cur_oh && (prev_state == ST_SO) && prev_cs_n &&
                             prev_hlda && (bus.state != ST_S1);
    chk[CHK_DACK_MULTI]    = !$onehot0(bus.DACK);
    chk[CHK_DACK_NOREQ]    = |(bus.DACK & ~prev_dack & ~prev_dreq);
    chk[CHK_DACK_IDLE]     = (|bus.DACK) && ((bus.state == ST_SI) || (bus.state == ST_SO));
    chk[CHK_IORW_BOTH]     = !bus.IOR_N && !bus.IOW_N;
    chk[CHK_CS_ACTIVE]     = !bus.CS_N && ((bus.state == ST_S1) || (bus.state == ST_S2) ||
                                           (bus.state == ST_S3) || (bus.state == ST_S4));
  end

  always_comb begin
    low_id = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--)
      if (chk[i]) low_id = 3'(i);
  end

  assign any_err = |chk;

  // clr empties the capture first, so a violation in the clr cycle is recorded.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      err_sticky      <= '0;
      err_pulse       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_id    <= '0;
    end else begin
      err_sticky <= (clr ? '0 : err_sticky) | chk;
      err_pulse  <= any_err;
      if (any_err && (clr || !first_err_valid)) begin
        first_err_valid <= 1'b1;
        first_err_id    <= low_id;
      end else if (clr) begin
        first_err_valid <= 1'b0;
        first_err_id    <= '0;
      end
    end
  end

  dma_mon_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(CLK), .rst_n(RESET_N), .clr(clr), .inc(any_err), .q(err_count)
  );

`ifdef DMA_MON_COVER_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_dack_cnt
    dma_mon_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(CLK), .rst_n(RESET_N), .clr(clr),
      .inc(bus.DACK[i] & ~prev_dack[i]),
      .q(dack_count[i*CNT_W +: CNT_W])
    );
  end

  dma_mon_sat_cnt #(.CNT_W(CNT_W)) u_so_cnt (
    .clk(CLK), .rst_n(RESET_N), .clr(clr),
    .inc((bus.state == ST_SO) && (prev_state != ST_SO)),
    .q(so_visits)
  );
`else
  assign dack_count = '0;
  assign so_visits  = '0;
`endif

endmodule
